// File: rtl/upsample_stream_ctrl_if.sv
// Pixel stream bundle for the 2x upsample controller.
// The master side is the controller, the slave side is its environment.
interface upsample_stream_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_row_last;
    logic             out_frame_last;

    modport master (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_row_last,
        output out_frame_last
    );

    modport slave (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_row_last,
        input  out_frame_last
    );
endinterface

// File: rtl/upsample_stream_ctrl.sv
// 2x nearest-neighbour upsample sequencer: buffers one input row,
// then replays it twice with every pixel duplicated horizontally.
module upsample_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 2,
    parameter int W          = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    upsample_stream_ctrl_if.master bus
);
    localparam int PW = DATA_WIDTH * D;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int OW = $clog2(2 * W);
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    localparam logic [IW-1:0] ICOL_MAX = IW'(W - 1);
    localparam logic [OW-1:0] OCOL_MAX = OW'(2 * W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] icol;
    logic [IW-1:0] icol_nxt;
    logic [OW-1:0] ocol;
    logic [OW-1:0] ocol_nxt;
    logic          rep;
    logic          rep_nxt;
    logic [RW-1:0] row;
    logic [RW-1:0] row_nxt;
    logic          wr_en;
    logic          row_end;
    logic [IW-1:0] rd_idx;

    logic [PW-1:0] line_buf [W];

    assign row_end = (ocol == OCOL_MAX);
    assign rd_idx  = IW'(ocol >> 1);

    always_comb begin
        state_nxt = state;
        icol_nxt  = icol;
        ocol_nxt  = ocol;
        rep_nxt   = rep;
        row_nxt   = row;
        wr_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FILL;
                    row_nxt   = '0;
                    icol_nxt  = '0;
                end
            end
            ST_FILL: begin
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (icol == ICOL_MAX) begin
                        state_nxt = ST_EMIT;
                        ocol_nxt  = '0;
                        rep_nxt   = 1'b0;
                    end else begin
                        icol_nxt = icol + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    if (!row_end) begin
                        ocol_nxt = ocol + 1'b1;
                    end else if (!rep) begin
                        rep_nxt  = 1'b1;
                        ocol_nxt = '0;
                    end else if (row != ROW_MAX) begin
                        row_nxt   = row + 1'b1;
                        icol_nxt  = '0;
                        state_nxt = ST_FILL;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            icol  <= '0;
            ocol  <= '0;
            rep   <= 1'b0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            icol  <= icol_nxt;
            ocol  <= ocol_nxt;
            rep   <= rep_nxt;
            row   <= row_nxt;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            line_buf[icol] <= bus.in_data;
        end
    end

    assign busy               = (state != ST_IDLE);
    assign done               = (state == ST_DONE);
    assign bus.in_ready       = (state == ST_FILL);
    assign bus.out_valid      = (state == ST_EMIT);
    assign bus.out_data       = (state == ST_EMIT) ? line_buf[rd_idx] : '0;
    assign bus.out_row_last   = (state == ST_EMIT) && row_end;
    assign bus.out_frame_last = (state == ST_EMIT) && row_end && rep &&
                                (row == ROW_MAX);
endmodule

// File: tb/tb_upsample_stream_ctrl.sv
// Directed bench for upsample_stream_ctrl: 2x2 and 1x1 frames,
// stalls, stray starts, mid-frame reset and back-to-back frames.
module tb_upsample_stream_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a;
    logic busy_a;
    logic done_a;
    logic start_b;
    logic busy_b;
    logic done_b;

    upsample_stream_ctrl_if #(.WIDTH(16)) ia ();
    upsample_stream_ctrl_if #(.WIDTH(32)) ib ();

    upsample_stream_ctrl #(
        .DATA_WIDTH(16), .D(1), .H(2), .W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .busy(busy_a), .done(done_a), .bus(ia)
    );

    upsample_stream_ctrl #(
        .DATA_WIDTH(16), .D(2), .H(1), .W(1)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .busy(busy_b), .done(done_b), .bus(ib)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            check({nm, "_idle_busy"}, busy_a, 1'b0);
            check({nm, "_idle_done"}, done_a, 1'b0);
            check({nm, "_idle_ovalid"}, ia.out_valid, 1'b0);
        end
    endtask

    task automatic run_frame(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3,
                             input bit stall, input bit extra_start,
                             input bit abort6, input string nm);
        logic [15:0] px [4];
        logic [15:0] hold_d;
        int in_idx   = 0;
        int out_idx  = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        bit hold     = 1'b0;
        bit aborted  = 1'b0;
        px = '{p0, p1, p2, p3};
        hold_d = '0;
        start_a = 1'b1;
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            start_a = extra_start &&
                      (cyc == 2 || cyc == 6 || cyc == 12 || cyc == 15);
            if (aborted) begin
                reset = 1'b0;
                check({nm, "_abort_busy"}, busy_a, 1'b0);
                check({nm, "_abort_ovalid"}, ia.out_valid, 1'b0);
                check({nm, "_abort_iready"}, ia.in_ready, 1'b0);
                check({nm, "_abort_done"}, done_a, 1'b0);
                return;
            end
            if (done_cnt > 0) begin
                check({nm, "_post_busy"}, busy_a, 1'b0);
                break;
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold) begin
                check({nm, "_stall_valid"}, ia.out_valid, 1'b1);
                check({nm, "_stall_data"}, ia.out_data, hold_d);
            end
            ia.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ia.in_valid  = stall ? (cyc % 2 == 0) : 1'b1;
            ia.in_data   = (in_idx < 4) ? px[in_idx] : 16'h0;
            if (ia.in_valid && ia.in_ready) in_idx++;
            hold   = ia.out_valid && !ia.out_ready;
            hold_d = ia.out_data;
            if (ia.out_valid && ia.out_ready) begin
                if (abort6 && out_idx == 5) begin
                    reset   = 1'b1;
                    aborted = 1'b1;
                end else begin
                    check({nm, "_data"}, ia.out_data,
                          px[((out_idx / 8) * 2 + (out_idx % 4) / 2) % 4]);
                    check({nm, "_row_last"}, ia.out_row_last,
                          (out_idx % 4) == 3);
                    check({nm, "_frame_last"}, ia.out_frame_last,
                          out_idx == 15);
                    out_idx++;
                end
            end
        end
        check({nm, "_out_count"}, out_idx, 16);
        check({nm, "_in_count"}, in_idx, 4);
        check({nm, "_done_count"}, done_cnt, 1);
        if (!stall) check({nm, "_done_cycle"}, done_cyc, 21);
    endtask

    initial begin
        int k;
        int dcnt;
        int dcyc;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ia.in_valid = 1'b0;
        ia.in_data = '0;
        ia.out_ready = 1'b0;
        ib.in_valid = 1'b0;
        ib.in_data = '0;
        ib.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_iready", ia.in_ready, 1'b0);
        check("rst_ovalid", ia.out_valid, 1'b0);
        check("rst_row_last", ia.out_row_last, 1'b0);
        check("rst_frame_last", ia.out_frame_last, 1'b0);
        check("rst_odata", ia.out_data, 16'h0);
        check("rst_busy_b", busy_b, 1'b0);
        reset = 1'b0;
        idle(2, "pre");

        run_frame(16'h4000, 16'hC000, 16'h0000, 16'h1000, 0, 0, 0, "s1");
        idle(3, "s1");
        run_frame(16'hC000, 16'h2300, 16'h1100, 16'h2222, 1, 0, 0, "s2");
        idle(3, "s2");
        run_frame(16'h4000, 16'hC000, 16'h0000, 16'h1000, 0, 1, 0, "s3");
        idle(3, "s3");
        run_frame(16'h4000, 16'hC000, 16'h0000, 16'h1000, 0, 0, 1, "s4");
        run_frame(16'h4000, 16'hC000, 16'h0000, 16'h1000, 0, 0, 0, "s4b");
        idle(2, "s4");
        run_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0, 0, "s5a");
        run_frame(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 0, 0, 0, "s5b");
        idle(2, "s5");

        k = 0;
        dcnt = 0;
        dcyc = -1;
        @(negedge clk);
        start_b = 1'b1;
        ib.in_valid = 1'b1;
        ib.in_data = 32'hABCD1234;
        ib.out_ready = 1'b1;
        for (int cyc = 1; cyc < 40; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (dcnt > 0 && cyc > dcyc + 2) break;
            if (done_b) begin
                dcnt++;
                dcyc = cyc;
            end
            if (ib.out_valid) begin
                check("s6_data", ib.out_data, 32'hABCD1234);
                check("s6_row_last", ib.out_row_last, (k % 2) == 1);
                check("s6_frame_last", ib.out_frame_last, k == 3);
                k++;
            end
        end
        check("s6_out_count", k, 4);
        check("s6_done_count", dcnt, 1);
        check("s6_done_cycle", dcyc, 6);
        check("s6_post_busy", busy_b, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
